// File: rtl/stream_packetizer.sv
// Wraps each upstream payload word into a single-flit packet with the configured destination header,
// buffering up to two packets and gating acceptance on network credits.
module stream_packetizer #(
    parameter int PAYLOAD_BITS = 32,
    parameter int ADDR_BITS    = 5,
    parameter int PORT_BITS    = 4,
    parameter int MAX_CREDITS  = 8,
    localparam int PACKET_BITS = 1 + ADDR_BITS + PORT_BITS + PAYLOAD_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    val_in,
    output logic                    ready_upward,
    input  logic                    cfg_wr,
    input  logic [ADDR_BITS-1:0]    cfg_dest_addr,
    input  logic [PORT_BITS-1:0]    cfg_dest_port,
    output logic                    configured,
    output logic [PACKET_BITS-1:0]  packet_out,
    output logic                    packet_valid,
    input  logic                    packet_ready,
    input  logic                    credit_return,
    output logic [3:0]              credits,
    output logic                    credit_overflow
);

    localparam logic [3:0] CREDIT_MAX = 4'(MAX_CREDITS);

    logic                   configured_q, configured_d;
    logic [ADDR_BITS-1:0]   dest_addr_q, dest_addr_d;
    logic [PORT_BITS-1:0]   dest_port_q, dest_port_d;
    logic [PACKET_BITS-1:0] head_q, head_d;
    logic [PACKET_BITS-1:0] tail_q, tail_d;
    logic [1:0]             occ_q, occ_d;
    logic [3:0]             credits_q, credits_d;
    logic                   overflow_q, overflow_d;

    logic                   accept;
    logic                   pop;
    logic [PACKET_BITS-1:0] new_pkt;

    // Acceptance depends only on registered state so upstream sees no combinational path from the network.
    assign ready_upward = configured_q && (credits_q != 4'd0) && (occ_q != 2'd2);
    assign accept       = val_in && ready_upward;
    assign pop          = (occ_q != 2'd0) && packet_ready;
    assign new_pkt      = {1'b1, dest_addr_q, dest_port_q, din};

    always_comb begin
        configured_d = configured_q;
        dest_addr_d  = dest_addr_q;
        dest_port_d  = dest_port_q;
        if (cfg_wr) begin
            configured_d = 1'b1;
            dest_addr_d  = cfg_dest_addr;
            dest_port_d  = cfg_dest_port;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (accept) begin
                    head_d = new_pkt;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (pop && accept) begin
                    head_d = new_pkt;
                end else if (pop) begin
                    occ_d = 2'd0;
                end else if (accept) begin
                    tail_d = new_pkt;
                    occ_d  = 2'd2;
                end
            end
            2'd2: begin
                // A full buffer never accepts, so only the tail-to-head shift is possible here.
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        if (accept && !credit_return) begin
            credits_d = credits_q - 4'd1;
        end else if (credit_return && !accept) begin
            if (credits_q == CREDIT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            configured_q <= 1'b0;
            dest_addr_q  <= '0;
            dest_port_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= 2'd0;
            credits_q    <= CREDIT_MAX;
            overflow_q   <= 1'b0;
        end else begin
            configured_q <= configured_d;
            dest_addr_q  <= dest_addr_d;
            dest_port_q  <= dest_port_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            credits_q    <= credits_d;
            overflow_q   <= overflow_d;
        end
    end

    assign configured      = configured_q;
    assign packet_valid    = (occ_q != 2'd0);
    assign packet_out      = packet_valid ? head_q : '0;
    assign credits         = credits_q;
    assign credit_overflow = overflow_q;

endmodule

// File: doc/stream_packetizer.md
# stream_packetizer

Downstream neighbour of the output stream FIFO: consumes its valid/ready word stream (`dout`/`val_out`/`ready_downward`) and turns each word into a single-flit network packet tagged with a configured destination leaf and port. It also enforces credit-based flow control toward the network. A 2-entry output buffer decouples the upstream handshake from network backpressure.

## Interface
- `PAYLOAD_BITS`, 32, payload word width
- `ADDR_BITS`, 5, destination leaf address width
- `PORT_BITS`, 4, destination port width
- `MAX_CREDITS`, 8, credits available after reset; range 1..15
- `PACKET_BITS` (localparam), 1+ADDR_BITS+PORT_BITS+PAYLOAD_BITS
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `din`  in  PAYLOAD_BITS  word from upstream FIFO (`dout`)
- `val_in`  in  1  upstream word valid (`val_out`)
- `ready_upward`  out  1  block accepts word this cycle (drives upstream `ready_downward`)
- `cfg_wr`  in  1  load destination registers
- `cfg_dest_addr`  in  ADDR_BITS  destination leaf
- `cfg_dest_port`  in  PORT_BITS  destination port
- `configured`  out  1  destination has been loaded since reset
- `packet_out`  out  PACKET_BITS  {1'b1, dest_addr, dest_port, payload}; all-zero when empty
- `packet_valid`  out  1  packet_out holds a packet
- `packet_ready`  in  1  network accepts packet
- `credit_return`  in  1  one-cycle pulse, one credit back from receiver
- `credits`  out  4  current credit count
- `credit_overflow`  out  1  sticky: credit_return arrived with credits == MAX_CREDITS

## Operation
- Config: `cfg_wr`=1 registers addr/port and sets `configured`=1 next edge. New destination applies only to words accepted after that edge; words already buffered keep their captured header.
- Accept: `ready_upward` = configured && credits != 0 && occupancy < 2; derived from registers only, never from `packet_ready` or `val_in`. Transfer when `val_in` && `ready_upward`.
- On accept, packet {1, dest_addr, dest_port, din} is pushed into the 2-entry buffer (head + tail, FIFO order).
- Pop when `packet_valid` && `packet_ready`; tail moves to head the same edge.
- Simultaneous push and pop: occupancy unchanged, order preserved. With occupancy 1, the popped head is replaced by the new word.
- Credits: accept → −1; `credit_return` → +1; both same cycle → unchanged. At MAX_CREDITS, `credit_return` without accept is dropped and `credit_overflow` sets (cleared only by reset). Credits never underflow because accept requires credits != 0.
- `packet_valid` = occupancy != 0; `packet_out` = head entry, or 0 when occupancy = 0.
- `cfg_wr` while `configured`=1 does not drop `ready_upward`.

## Timing
- Reset values: `ready_upward` 0, `packet_valid` 0, `packet_out` 0, `configured` 0, `credits` MAX_CREDITS, `credit_overflow` 0, dest registers 0, occupancy 0.
- Reset mid-operation: buffered packets are discarded and credits are restored to MAX_CREDITS. Upstream is reset by the same signal.
- Latency: word accepted at edge N → `packet_valid`=1 with that packet during cycle N+1.
- Throughput: 1 packet/cycle sustained while `packet_ready`=1 and credits > 0.
- Backpressure: with `packet_ready`=0, at most 2 words are accepted, then `ready_upward` falls in the cycle after occupancy reaches 2.
- Credit stall: `ready_upward` falls in the cycle after credits reach 0. It rises the cycle after a `credit_return` edge.
- `packet_out`/`packet_valid` hold stable while `packet_valid`=1 && `packet_ready`=0.

## Test plan
- Reset, no cfg, `val_in`=1 for 10 cycles → `ready_upward` stays 0, `packet_valid` 0, credits 8.
- cfg addr=5'h03 port=4'h2; stream words 0x1..0x6 with `packet_ready`=1 and `credit_return` echoed from each packet with 4-cycle delay → six packets {1,03,2,0x1..0x6} in order, 1/cycle, first at the cycle after the first accept.
- `packet_ready`=0 and 5 words offered → exactly 2 accepted, `ready_upward` 0. Release `packet_ready` → words 1,2 exit in order, then remaining 3 flow.
- No credit_return, MAX_CREDITS=8, 12 words offered → 8 accepted, credits 0, `ready_upward` 0. One `credit_return` pulse → exactly 1 more word accepted.
- `cfg_wr` to addr 0x07 while 2 packets are buffered → buffered packets keep the old header; next accepted word carries 0x07. Same-cycle accept + `credit_return` → credits unchanged.
- `credit_return` with credits = 8 → `credit_overflow`=1 and credits stay at 8. Assert reset with occupancy 2 → next cycle `packet_valid` 0, credits 8, `credit_overflow` 0.
